// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Takes a multi-digit BCD result plus carry from the adder stage over a
//   valid/ready handshake and scans it onto a shared 7-segment bus with
//   one-hot digit enables. A shadow register holds the next value until the
//   current frame finishes, so a frame never shows a mix of old and new digits.
//
//   Optional build macro: BCD_LZB_EN enables leading-zero blanking (digits
//   k>=1 go dark while they and every more-significant digit are zero).
module bcd_display_scanner #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    input  logic                  in_carry,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_pulse
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PS_W  = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);

    logic [4*DIGITS-1:0] shadow_bcd;
    logic                shadow_carry;
    logic                pending;
    logic                pending_nxt;
    logic [4*DIGITS-1:0] disp_bcd;
    logic                disp_carry;
    logic [PS_W-1:0]     prescaler;
    logic [IDX_W-1:0]    digit_idx;
    logic                commit_q;

    logic                tc;
    logic                frame_end;
    logic                accept;
    logic                commit;
    logic [3:0]          cur_nib;
    logic                blank;
    logic [6:0]          glyph;

    assign tc        = (prescaler == PS_LAST);
    assign frame_end = tc && (digit_idx == IDX_LAST);
    assign accept    = in_valid && in_ready;
    assign commit    = frame_end && pending;

    // Scan timing: prescaler counts SCAN_DIV cycles per digit, index steps on TC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            prescaler <= tc ? '0 : prescaler + PS_W'(1);
            if (tc)
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end
    end

    // Next value of the pending flag: set on accept, cleared on commit.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        pending_nxt = pending;
        if (accept)
            pending_nxt = 1'b1;
        else if (commit)
            pending_nxt = 1'b0;
    end

    // Shadow capture and handshake; in_ready is the registered inverse of pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_bcd   <= '0;
            shadow_carry <= 1'b0;
            pending      <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            if (accept) begin
                shadow_bcd   <= in_bcd;
                shadow_carry <= in_carry;
            end
            pending  <= pending_nxt;
            in_ready <= !pending_nxt;
        end
    end

    // Display register loads from the shadow only at a frame boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_bcd   <= '0;
            disp_carry <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            if (commit) begin
                disp_bcd   <= shadow_bcd;
                disp_carry <= shadow_carry;
            end
            commit_q <= commit;
        end
    end

    // Decode the nibble under the current digit index, with optional blanking.
    always_comb begin
        cur_nib = disp_bcd[4*int'(digit_idx) +: 4];
`ifdef BCD_LZB_EN
        blank = (digit_idx != '0);
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(digit_idx) && disp_bcd[4*j +: 4] != 4'd0)
                blank = 1'b0;
        end
`else
        blank = 1'b0;
`endif
        case (cur_nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h79;
        endcase
        if (blank)
            glyph = 7'h00;
    end

    // Output stage; frame_pulse is delayed to line up with the first new glyph.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg         <= 7'h00;
            dp          <= 1'b0;
            an          <= '0;
            frame_pulse <= 1'b0;
        end else begin
            seg         <= glyph;
            dp          <= disp_carry && (digit_idx == IDX_LAST);
            an          <= DIGITS'(1) << digit_idx;
            frame_pulse <= commit_q;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with DIGITS=4, SCAN_DIV=4.
// Outputs are sampled on the falling clock edge.
module tb_bcd_display_scanner;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
`ifdef BCD_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] Z = LZB ? 7'h00 : 7'h3F;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [4*DIGITS-1:0] in_bcd = '0;
    logic                in_carry = 1'b0;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_pulse;

    int n_cmp = 0;
    int n_err = 0;

    bcd_display_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bcd      (in_bcd),
        .in_carry    (in_carry),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_pulse (frame_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a value at a falling edge and wait (bounded) until it is taken.
    task automatic offer(input string tag, input logic [15:0] bcd, input logic carry);
        bit taken = 1'b0;
        in_bcd   = bcd;
        in_carry = carry;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !taken; i++) begin
            if (in_ready === 1'b1) taken = 1'b1;
            else @(negedge clk);
        end
        if (!taken) check({tag, "_offer_timeout"}, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_ready_low"}, in_ready, 0);
    endtask

    // Wait (bounded) for frame_pulse; report in_ready activity seen before it.
    task automatic wait_pulse(input string tag, output int hi_cnt, output logic last_ready);
        bit seen = 1'b0;
        hi_cnt = 0;
        last_ready = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (frame_pulse === 1'b1) seen = 1'b1;
            else begin
                if (in_ready === 1'b1) hi_cnt++;
                last_ready = in_ready;
            end
        end
        if (!seen) check({tag, "_pulse_timeout"}, 0, 1);
    endtask

    // Starting at the frame_pulse sample, check each digit of one frame.
    task automatic check_frame(input string tag, input logic [27:0] exp, input logic carry);
        for (int k = 0; k < DIGITS; k++) begin
            if (k > 0) repeat (SCAN_DIV) @(negedge clk);
            check($sformatf("%s_d%0d_an", tag, k), an, 32'(1) << k);
            check($sformatf("%s_d%0d_seg", tag, k), seg, exp[7*k +: 7]);
            check($sformatf("%s_d%0d_dp", tag, k), dp, (k == DIGITS-1) ? carry : 1'b0);
        end
        check({tag, "_pulse_single"}, frame_pulse, 0);
    endtask

    initial begin
        int   hi;
        logic lr;
        int   bad;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_seg", seg, 0);
        check("rst_an", an, 0);
        check("rst_dp", dp, 0);
        check("rst_ready", in_ready, 1);
        check("rst_pulse", frame_pulse, 0);
        reset_n = 1'b1;

        // Idle scan: each digit for SCAN_DIV cycles, showing 0.
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            check($sformatf("scan_an_%0d", n), an, 32'(1) << ((n - 1) / SCAN_DIV));
            check($sformatf("scan_seg_%0d", n), seg, 7'h3F);
            check($sformatf("scan_pulse_%0d", n), frame_pulse, 0);
        end

        // 1234, no carry.
        offer("v1234", 16'h1234, 1'b0);
        wait_pulse("v1234", hi, lr);
        check("v1234_ready_hi_cnt", hi, 1);
        check("v1234_ready_before_pulse", lr, 1);
        check("v1234_ready_at_pulse", in_ready, 1);
        check_frame("v1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0);

        // 00A9 with carry: error glyph on digit 1, dp on top digit only.
        offer("v00a9", 16'h00A9, 1'b1);
        wait_pulse("v00a9", hi, lr);
        check_frame("v00a9", {Z, Z, 7'h79, 7'h6F}, 1'b1);

        // Back-to-back: 1111 then 2222 held on the bus.
        @(negedge clk);
        offer("b2b_first", 16'h1111, 1'b0);
        in_bcd   = 16'h2222;
        in_valid = 1'b1;
        wait_pulse("b2b_first", hi, lr);
        in_valid = 1'b0;
        check("b2b_ready_hi_cnt", hi, 1);
        check("b2b_ready_before_pulse", lr, 1);
        check("b2b_second_taken", in_ready, 0);
        check_frame("b2b_1111", {7'h06, 7'h06, 7'h06, 7'h06}, 1'b0);
        wait_pulse("b2b_second", hi, lr);
        check_frame("b2b_2222", {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 1'b0);

        // Frame boundaries without a pending value: no pulse, display held.
        bad = 0;
        for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) begin
            @(negedge clk);
            if (frame_pulse !== 1'b0 || seg !== 7'h5B) bad++;
        end
        check("idle_no_pulse", bad, 0);

        // Leading-zero cases.
        offer("v0005", 16'h0005, 1'b0);
        wait_pulse("v0005", hi, lr);
        check_frame("v0005", {Z, Z, Z, 7'h6D}, 1'b0);
        offer("v0000", 16'h0000, 1'b0);
        wait_pulse("v0000", hi, lr);
        check_frame("v0000", {Z, Z, Z, 7'h3F}, 1'b0);

        // Reset with a value pending: discarded, no pulse afterwards.
        offer("v9999", 16'h9999, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_seg", seg, 0);
        check("mid_rst_an", an, 0);
        check("mid_rst_dp", dp, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_pulse", frame_pulse, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_an", an, 1);
        bad = 0;
        for (int i = 0; i < 3 * DIGITS * SCAN_DIV; i++) begin
            if (frame_pulse !== 1'b0 || seg !== 7'h3F || in_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        check("post_rst_quiet", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

- Downstream consumer of the BCD adder stage.
- Accepts a multi-digit BCD result plus carry/overflow flag over a valid/ready handshake.
- Double-buffers the value so the display never tears mid-frame.
- Time-multiplexes the digits onto a shared 7-segment bus with one-hot digit enables; out-of-range nibbles show an error glyph.

## Interface
- DIGITS, default 4: number of BCD digits, ≥1; digit 0 is least significant.
- SCAN_DIV, default 1000: clk cycles each digit is driven, ≥2.
- clk  input  1: clock, all state on rising edge.
- reset_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: in_bcd/in_carry valid this cycle.
- in_ready  output  1: block can accept a new value.
- in_bcd  input  4*DIGITS: BCD value, nibble k = digit k.
- in_carry  input  1: overflow/carry from the adder, shown as decimal point on digit DIGITS-1.
- seg  output  7: segments {g,f,e,d,c,b,a}, active-high.
- dp  output  1: decimal point, active-high.
- an  output  DIGITS: one-hot digit enable, active-high.
- frame_pulse  output  1: one-cycle pulse when a new value is committed to the display.

## Operation
- State:
  - shadow register (value + carry) with a pending flag.
  - display register (value + carry).
  - prescaler 0..SCAN_DIV-1.
  - digit index 0..DIGITS-1, width max(1,$clog2(DIGITS)).
- Accept: in_valid && in_ready loads shadow and sets pending. in_ready = !pending, registered.
- Prescaler increments every cycle and wraps at SCAN_DIV-1 (terminal count, TC).
- On TC the digit index advances and wraps DIGITS-1→0.
- Frame boundary = TC && index==DIGITS-1. At a frame boundary with pending=1:
  - display ← shadow;
  - pending ← 0;
  - frame_pulse asserted next cycle.
- A frame boundary with pending=0 leaves the display unchanged and does not pulse frame_pulse.
- Accept and commit cannot coincide: in_ready is low whenever pending=1.
- Decode of displayed nibble:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - 10–15→79 (error "E").
- an = one-hot(index).
- dp = display carry when index==DIGITS-1, else 0.
- The carry bit does not affect any other digit.

## Timing
- Reset values:
  - Outputs: seg=0, dp=0, an=0, in_ready=1, frame_pulse=0.
  - Internal: display=0, shadow=0, pending=0, prescaler=0, index=0.
- seg/dp/an are registered from index and display, one cycle behind them.
- First cycle after reset release: outputs still at reset values.
- From the second cycle after reset release: an=0…01, seg=3F.
- Each digit is driven for exactly SCAN_DIV cycles. A full frame is DIGITS*SCAN_DIV cycles.
- Accept→commit latency: up to one frame.
- Commit cycle → new glyph on digit 0: 2 cycles. frame_pulse and the new digit-0 output appear together.
- in_ready returns high the cycle after commit.
- When in_ready is low, in_valid is ignored and in_bcd is not sampled. Upstream holds the data.
- DIGITS=1: every TC is a frame boundary, and an is constantly 1 after reset.
- reset_n asserted mid-frame or with pending=1:
  - all state clears immediately;
  - the pending value is discarded;
  - no frame_pulse is issued.

## Configuration
- BCD_LZB_EN defined: leading-zero blanking.
  - Digit k (k≥1) drives seg=0 when its nibble and every more-significant nibble are 0.
  - Digit 0 is never blanked.
  - an timing is unchanged.
  - dp is unaffected by blanking.
- BCD_LZB_EN undefined: every digit always shows its decoded glyph.

## Test plan
- Reset release (DIGITS=4, SCAN_DIV=4) -> in_ready=1 and outputs 0 in the reset cycle. Then an=0001, seg=3F, and an rotates 0010, 0100, 1000 every 4 cycles. frame_pulse stays 0.
- Load in_bcd=16'h1234, in_carry=0 -> in_ready low next cycle. At the next frame boundary frame_pulse=1, then digits 0..3 show 66, 4F, 5B, 06 with dp=0 throughout.
- Load 16'h00A9 with in_carry=1 -> digit0=6F, digit1=79.
  - With BCD_LZB_EN: digits 2–3 seg=00.
  - Without BCD_LZB_EN: digits 2–3 seg=3F.
  - In both cases dp=1 only while an=1000.
- Back-to-back offers: in_valid held with 16'h1111, then 16'h2222 -> second value not accepted until the cycle after the commit of 1111. No frame ever mixes 1 and 2 glyphs.
- BCD_LZB_EN with 16'h0005 -> digits 3..1 seg=00, digit0=6D. 16'h0000 -> only digit0=3F lit.
- Accept 16'h9999, then pulse reset_n low mid-frame before commit -> all outputs and state at reset values. After release the display shows 0000, in_ready=1, and no frame_pulse occurs.
